// File: rtl/cpld_io_pkg.sv
// cpld_io_pkg: shared frame geometry and field positions for the CPLD side of
// the FPGA simple-I/O serial link.
// Contents: frame length, bit-counter width, TX field positions, RX frame
// layout struct, and a helper that builds the word returned on cpld_miso.
package cpld_io_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int DIP_W      = 8;
  localparam int NAV_W      = 5;

  // Positions inside the word sent back to the FPGA
  localparam int TX_SEL     = 14;
  localparam int TX_NAV_LSB = 9;
  localparam int TX_DIP_LSB = 1;

  typedef logic [FRAME_BITS-1:0] frame_t;

  // Received frame layout: segment pattern in the upper byte, LEDs in the lower
  typedef struct packed {
    logic [7:0] seg;
    logic [7:0] led;
  } rx_frame_t;

  function automatic frame_t tx_word(input logic             sel,
                                     input logic [NAV_W-1:0] nav,
                                     input logic [DIP_W-1:0] dip);
    frame_t w;
    w                        = '0;
    w[TX_SEL]                = sel;
    w[TX_NAV_LSB +: NAV_W]   = nav;
    w[TX_DIP_LSB +: DIP_W]   = dip;
    return w;
  endfunction

endpackage

// File: rtl/cpld_io_sync.sv
// cpld_io_sync: STAGES-deep flop synchroniser for asynchronous inputs, with an
// optional rise/fall detector on the synchronised level.
// Latency: o_dat follows i_dat after STAGES clk; o_rise/o_fall are high for the
// one clk in which o_dat changes, so a consumer acts STAGES+1 clk after the pin.
// Backpressure: none, free-running.
// Ports: clk, rstn (sync, active-low), i_dat (async in), o_dat (synchronised),
//        o_rise / o_fall (one-clk strobes, tied low when EDGE_DET is 0).
module cpld_io_sync #(
  parameter int STAGES   = 2,
  parameter int WIDTH    = 1,
  parameter bit EDGE_DET = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_dat;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_dat = r_stage[STAGES-1];

  generate
    if (EDGE_DET) begin : g_edge
      logic [WIDTH-1:0] r_prev;

      always_ff @(posedge clk) begin
        if (!rstn) r_prev <= '0;
        else       r_prev <= o_dat;
      end

      assign o_rise = o_dat & ~r_prev;
      assign o_fall = ~o_dat & r_prev;
    end else begin : g_no_edge
      assign o_rise = '0;
      assign o_fall = '0;
    end
  endgenerate

endmodule

// File: rtl/cpld_io_slave.sv
// cpld_io_slave: CPLD end of the 16-bit FPGA serial link; receives LED and
// 7-segment frames, returns switch state, drives LEDs and a 2-digit display.
// Latency: frame takes effect SYNC_STAGES+1 clk after the final cpld_clk rise;
// backpressure: none, the FPGA owns framing, malformed frames raise frame_err.
// Optional feature macro: LINK_WDOG_EN (link-loss watchdog blanks the outputs).
// Ports:
//   clk, rstn            CPLD clock, synchronous active-low reset
//   cpld_clk/load/mosi   serial link from FPGA (async, LSB first, load on bit 15)
//   cpld_miso            serial link to FPGA, changes on cpld_clk falls
//   dipsw, navsw         async switches, returned in the next TX word
//   led                  active-high LEDs
//   seg_n, dig_n         active-low segments {dp,g..a} and digit enables
//   frame_err            one-clk pulse when load arrives on the wrong bit
module cpld_io_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int MUX_DIV     = 4096,
  parameter int WDOG_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cpld_clk,
  input  logic       cpld_load,
  input  logic       cpld_mosi,
  output logic       cpld_miso,
  input  logic [7:0] dipsw,
  input  logic [4:0] navsw,
  output logic [7:0] led,
  output logic [7:0] seg_n,
  output logic [1:0] dig_n,
  output logic       frame_err
);

  import cpld_io_pkg::*;

  localparam int MUX_W = (MUX_DIV > 1) ? $clog2(MUX_DIV) : 1;

  generate
    if (SYNC_STAGES < 2 || MUX_DIV < 2 || WDOG_CYCLES < 1) begin : g_bad_param
      $error("cpld_io_slave: SYNC_STAGES>=2, MUX_DIV>=2, WDOG_CYCLES>=1 required");
    end
  endgenerate

  // ---------------------------------------------------------------- sync
  logic             w_clk_rise;
  logic             w_clk_fall;
  logic             w_cclk_lvl_unused;
  logic             w_load_s;
  logic             w_mosi_s;
  logic [DIP_W-1:0] w_dip_s;
  logic [NAV_W-1:0] w_nav_s;
  logic [14:0]      w_data_rise_unused;
  logic [14:0]      w_data_fall_unused;

  cpld_io_sync #(
    .STAGES   (SYNC_STAGES),
    .WIDTH    (1),
    .EDGE_DET (1'b1)
  ) u_sync_cclk (
    .clk    (clk),
    .rstn   (rstn),
    .i_dat  (cpld_clk),
    .o_dat  (w_cclk_lvl_unused),
    .o_rise (w_clk_rise),
    .o_fall (w_clk_fall)
  );

  cpld_io_sync #(
    .STAGES   (SYNC_STAGES),
    .WIDTH    (15),
    .EDGE_DET (1'b0)
  ) u_sync_data (
    .clk    (clk),
    .rstn   (rstn),
    .i_dat  ({navsw, dipsw, cpld_mosi, cpld_load}),
    .o_dat  ({w_nav_s, w_dip_s, w_mosi_s, w_load_s}),
    .o_rise (w_data_rise_unused),
    .o_fall (w_data_fall_unused)
  );

  // ---------------------------------------------------------------- link
  logic [FRAME_BITS-1:0] r_rx_shr;
  logic [FRAME_BITS-1:0] r_tx_shr;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic                  r_miso;
  logic                  r_sel;
  logic                  r_frame_err;
  logic [7:0]            r_led;
  logic [7:0]            r_pat [2];

  frame_t    w_rx_next;
  rx_frame_t w_rx_fields;
  logic      w_cnt_last;

  // The bit arriving with load is shifted in before the frame is judged, so
  // fields are taken from the post-shift value.
  assign w_rx_next   = {w_mosi_s, r_rx_shr[FRAME_BITS-1:1]};
  assign w_rx_fields = rx_frame_t'(w_rx_next);
  assign w_cnt_last  = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rx_shr    <= '0;
      r_tx_shr    <= '0;
      r_bit_cnt   <= '0;
      r_miso      <= 1'b0;
      r_sel       <= 1'b0;
      r_frame_err <= 1'b0;
      r_led       <= '0;
      r_pat[0]    <= '0;
      r_pat[1]    <= '0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_clk_rise) begin
        r_rx_shr <= w_rx_next;
        if (w_load_s) begin
          r_bit_cnt <= '0;
          if (w_cnt_last) begin
            r_led        <= w_rx_fields.led;
            r_pat[r_sel] <= w_rx_fields.seg;
            r_sel        <= ~r_sel;
            r_tx_shr     <= tx_word(~r_sel, w_nav_s, w_dip_s);
          end else begin
            // Short/long frame: keep all display state, resync the TX word
            r_frame_err <= 1'b1;
            r_tx_shr    <= tx_word(r_sel, w_nav_s, w_dip_s);
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end else if (w_clk_fall) begin
        r_miso   <= r_tx_shr[0];
        r_tx_shr <= {1'b0, r_tx_shr[FRAME_BITS-1:1]};
      end
    end
  end

  assign cpld_miso = r_miso;
  assign frame_err = r_frame_err;

  // ---------------------------------------------------------------- display mux
  logic [MUX_W-1:0] r_mux_cnt;
  logic             r_dmux;
  logic             r_mux_on;   // digits stay dark until the first slot wrap

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mux_cnt <= '0;
      r_dmux    <= 1'b0;
      r_mux_on  <= 1'b0;
    end else if (r_mux_cnt == MUX_W'(MUX_DIV - 1)) begin
      r_mux_cnt <= '0;
      r_dmux    <= ~r_dmux;
      r_mux_on  <= 1'b1;
    end else begin
      r_mux_cnt <= r_mux_cnt + MUX_W'(1);
    end
  end

  // ---------------------------------------------------------------- watchdog
  logic w_blank;

`ifdef LINK_WDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wdog_cnt <= '0;
    end else if (w_clk_rise && w_load_s && w_cnt_last) begin
      r_wdog_cnt <= '0;
    end else if (r_wdog_cnt != WDOG_W'(WDOG_CYCLES)) begin
      r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
    end
  end

  // Blanking only masks the outputs; held LED/pattern registers survive.
  assign w_blank = (r_wdog_cnt == WDOG_W'(WDOG_CYCLES));
`else
  assign w_blank = 1'b0;
`endif

  // ---------------------------------------------------------------- outputs
  always_comb begin
    led   = r_led;
    seg_n = ~r_pat[r_dmux];
    dig_n = !r_mux_on ? 2'b11 : (r_dmux ? 2'b01 : 2'b10);
    if (w_blank) begin
      led   = '0;
      seg_n = 8'hFF;
      dig_n = 2'b11;
    end
  end

endmodule

// File: tb/tb_cpld_io_slave.sv
// tb_cpld_io_slave: directed frames on the serial link, a frame-level model of
// LED/pattern/select/TX-word state, and a per-cycle compare of led/seg_n/dig_n.
// Display timing is predicted from the count of clk edges since reset.
module tb_cpld_io_slave;

  localparam int MUX = 64;
  localparam int WDC = 1000;
`ifdef LINK_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic       clk       = 1'b0;
  logic       rstn      = 1'b0;
  logic       cpld_clk  = 1'b0;
  logic       cpld_load = 1'b0;
  logic       cpld_mosi = 1'b0;
  logic [7:0] dipsw     = 8'h00;
  logic [4:0] navsw     = 5'h00;
  logic       cpld_miso;
  logic       frame_err;
  logic [7:0] led;
  logic [7:0] seg_n;
  logic [1:0] dig_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpld_io_slave #(
    .SYNC_STAGES (2),
    .MUX_DIV     (MUX),
    .WDOG_CYCLES (WDC)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cpld_clk  (cpld_clk),
    .cpld_load (cpld_load),
    .cpld_mosi (cpld_mosi),
    .cpld_miso (cpld_miso),
    .dipsw     (dipsw),
    .navsw     (navsw),
    .led       (led),
    .seg_n     (seg_n),
    .dig_n     (dig_n),
    .frame_err (frame_err)
  );

  // ------------------------------------------------------------ model state
  logic [7:0]  m_led;
  logic [7:0]  m_pat [2];
  logic        m_sel;
  int          m_rises;
  logic [15:0] m_tx;
  int          k        = 0;  // clk edges since reset released
  int          m_idle   = 0;  // clk edges since reset or last accepted frame
  bit          chk_en   = 1'b1;
  int          err_seen = 0;
  logic        prev_err = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] tx_expect(input logic sel);
    return 16'((int'(sel) << 14) + (int'(navsw) << 9) + (int'(dipsw) << 1));
  endfunction

  task automatic model_reset();
    m_led   = 8'h00;
    m_pat[0] = 8'h00;
    m_pat[1] = 8'h00;
    m_sel   = 1'b0;
    m_rises = 0;
    m_tx    = 16'h0000;
  endtask

  // Sends nbits of w LSB first at clk/16; load accompanies the last bit if ld_last.
  task automatic send_frame(input logic [15:0] w, input int nbits, input bit ld_last,
                            output logic [15:0] cap);
    logic [15:0] mask;
    bit          last;
    cap  = 16'h0000;
    mask = 16'h0000;
    for (int i = 0; i < nbits; i++) begin
      last      = ld_last && (i == nbits - 1);
      cpld_mosi = w[i];
      cpld_load = last;
      tick(8);
      cap[i]  = cpld_miso;
      mask[i] = 1'b1;
      if (last) chk_en = 1'b0;
      cpld_clk = 1'b1;
      tick(8);
      if (last) begin
        chk("miso word", cap & mask, m_tx & mask);
        if (m_rises % 16 == 15) begin
          m_led        = w[7:0];
          m_pat[m_sel] = w[15:8];
          m_sel        = ~m_sel;
          m_idle       = 0;
        end
        m_tx    = tx_expect(m_sel);
        m_rises = 0;
        chk_en  = 1'b1;
      end else begin
        m_rises++;
      end
      cpld_clk = 1'b0;
    end
    cpld_load = 1'b0;
    cpld_mosi = 1'b0;
  endtask

  task automatic wait_dig(input logic [1:0] want);
    int n;
    n = 0;
    while (dig_n !== want && n < 4 * MUX) begin
      tick(1);
      n++;
    end
    chk("dig_n reached", {14'd0, dig_n}, {14'd0, want});
  endtask

  // ------------------------------------------------------------ per-cycle compare
  always @(posedge clk) begin
    int   dm;
    logic blank;
    logic skip;
    if (!rstn) begin
      k      = 0;
      m_idle = 0;
    end else begin
      k++;
      m_idle++;
    end
    #1;
    if (frame_err === 1'b1) begin
      err_seen++;
      chk("frame_err width", {15'd0, prev_err}, 16'd0);
    end
    prev_err = frame_err;
    if (chk_en) begin
      dm    = (k / MUX) % 2;
      blank = WDOG && (m_idle > WDC + 16);
      skip  = WDOG && (m_idle >= WDC - 16) && (m_idle <= WDC + 16);
      if (!skip) begin
        chk("led", {8'd0, led}, blank ? 16'd0 : {8'd0, m_led});
        chk("dig_n", {14'd0, dig_n},
            (blank || k < MUX) ? 16'd3 : (dm == 1 ? 16'd1 : 16'd2));
        chk("seg_n", {8'd0, seg_n}, blank ? 16'h00FF : {8'd0, ~m_pat[dm]});
      end
      chk("frame_err quiet", {15'd0, frame_err}, 16'd0);
    end
  end

  // ------------------------------------------------------------ safety bound
  initial begin
    #500_000;
    errors++;
    $display("FAIL timeout: run did not complete within bound");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  // ------------------------------------------------------------ directed stimulus
  initial begin
    logic [15:0] cap;
    int          e0;
    model_reset();
    tick(4);
    chk("reset led",   {8'd0, led},   16'h0000);
    chk("reset seg_n", {8'd0, seg_n}, 16'h00FF);
    chk("reset dig_n", {14'd0, dig_n}, 16'h0003);
    chk("reset miso",  {15'd0, cpld_miso}, 16'h0000);
    rstn = 1'b1;
    tick(5);

    send_frame(16'hA53C, 16, 1'b1, cap);
    chk("A53C led", {8'd0, led}, 16'h003C);
    wait_dig(2'b10);
    chk("A53C seg dig0", {8'd0, seg_n}, 16'h005A);

    send_frame(16'h06FF, 16, 1'b1, cap);
    chk("06FF led", {8'd0, led}, 16'h00FF);
    wait_dig(2'b01);
    chk("06FF seg dig1", {8'd0, seg_n}, 16'h00F9);

    dipsw = 8'hC3;
    navsw = 5'h15;
    tick(8);
    send_frame(16'h1234, 16, 1'b1, cap);
    send_frame(16'h5678, 16, 1'b1, cap);
    chk("miso switch word", cap, 16'h6B86);

    e0 = err_seen;
    send_frame(16'h0042, 10, 1'b1, cap);
    chk("short frame err count", 16'(err_seen - e0), 16'd1);
    chk("short frame led held", {8'd0, led}, 16'h0078);
    wait_dig(2'b10);
    chk("short frame pat0 held", {8'd0, seg_n}, 16'h00ED);
    wait_dig(2'b01);
    chk("short frame pat1 held", {8'd0, seg_n}, 16'h00A9);
    send_frame(16'hBEEF, 16, 1'b1, cap);
    chk("after short frame led", {8'd0, led}, 16'h00EF);
    chk("reloaded tx word", cap, 16'h2B86);

    cpld_load = 1'b1;
    tick(20);
    cpld_load = 1'b0;
    tick(4);
    chk("bare load err count", 16'(err_seen - e0), 16'd1);
    chk("bare load led", {8'd0, led}, 16'h00EF);

    send_frame(16'hCAFE, 8, 1'b0, cap);
    rstn = 1'b0;
    model_reset();
    tick(1);
    chk("midframe reset led",   {8'd0, led},   16'h0000);
    chk("midframe reset seg_n", {8'd0, seg_n}, 16'h00FF);
    chk("midframe reset dig_n", {14'd0, dig_n}, 16'h0003);
    chk("midframe reset miso",  {15'd0, cpld_miso}, 16'h0000);
    rstn = 1'b1;
    tick(3);
    send_frame(16'h8118, 16, 1'b1, cap);
    chk("post reset led", {8'd0, led}, 16'h0018);
    chk("post reset err count", 16'(err_seen - e0), 16'd1);

`ifdef LINK_WDOG_EN
    tick(WDC + 40);
    chk("wdog led blank", {8'd0, led}, 16'h0000);
    chk("wdog dig_n blank", {14'd0, dig_n}, 16'h0003);
    chk("wdog seg_n blank", {8'd0, seg_n}, 16'h00FF);
    send_frame(16'h3C3C, 16, 1'b1, cap);
    chk("wdog restored led", {8'd0, led}, 16'h003C);
`endif

    tick(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
